// File: rtl/aoi21_bist_pkg.sv
// Shared types, widths and the golden AOI21 reference used by the BIST sequencer.
package aoi21_bist_pkg;

  localparam int unsigned VEC_W   = 3;
  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned ERR_W   = 4;
  localparam int unsigned TMR_W   = 8;

  localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  // Vector is packed {A,B,C}.
  function automatic logic aoi21_golden(input logic [VEC_W-1:0] vec);
    return ~((vec[2] & vec[1]) | vec[0]);
  endfunction

endpackage

// File: rtl/aoi21_bist_timer.sv
// Loadable down-counter that parks at zero; paces the per-vector settle time.
module aoi21_bist_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/aoi21_bist_ctrl.sv
// BIST sequencer for one AOI21 cell: walks vectors 0..7, samples Y after a settle time,
// and reports pass/fail, a mismatch count and the first failing vector.
module aoi21_bist_ctrl
  import aoi21_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  input  logic             dut_y,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_vec,
  output logic             fail_valid
);

  localparam logic [TMR_W-1:0] SettleLoad = TMR_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
  logic               fail_valid_q, fail_valid_d;
  logic               pass_q, pass_d;

  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_zero;
  logic [TMR_W-1:0]   tmr_count;
  logic               mismatch;

  aoi21_bist_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (SettleLoad),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  assign mismatch = (dut_y != aoi21_golden(vec_q));

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d        = '0;
          fail_vec_d   = '0;
          fail_valid_d = 1'b0;
          pass_d       = 1'b0;
          vec_d        = '0;
          tmr_load     = 1'b1;
          state_d      = StSettle;
        end else begin
          state_d = StIdle;
        end
      end

      StSettle: begin
        tmr_en = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (tmr_zero) begin
          state_d = StSample;
        end
      end

      StSample: begin
        // The check still counts on an aborted sample cycle.
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fail_valid_q) begin
            fail_vec_d   = vec_q;
            fail_valid_d = 1'b1;
          end
        end
        if (abort) begin
          state_d = StIdle;
        end else if (vec_q == LAST_VEC) begin
          pass_d  = (err_d == '0);
          state_d = StDone;
        end else begin
          vec_d    = vec_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = StSettle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
    end
  end

  logic drive_pins;
  assign drive_pins = (state_q == StSettle) || (state_q == StSample);

  assign busy       = drive_pins;
  assign done       = (state_q == StDone);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;
  assign dut_a      = drive_pins & vec_q[2];
  assign dut_b      = drive_pins & vec_q[1];
  assign dut_c      = drive_pins & vec_q[0];

endmodule

// File: tb/tb_aoi21_bist_ctrl.sv
// Directed bench for aoi21_bist_ctrl with good, stuck-at-0 and C-open cell models.
module tb_aoi21_bist_ctrl;

  localparam int unsigned Settle  = 4;
  localparam int unsigned Latency = 8 * (Settle + 1) + 1;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       pass;
  logic       dut_a;
  logic       dut_b;
  logic       dut_c;
  logic       dut_y;
  logic [3:0] err_count;
  logic [2:0] fail_vec;
  logic       fail_valid;

  int unsigned model_mode;  // 0 good, 1 Y stuck-at-0, 2 C input open
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 CLK = ~CLK;

  always_comb begin
    dut_y = ~((dut_a & dut_b) | dut_c);
    if (model_mode == 1) dut_y = 1'b0;
    else if (model_mode == 2) dut_y = ~(dut_a & dut_b);
  end

  aoi21_bist_ctrl #(
    .SETTLE_CYCLES (Settle)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .dut_a      (dut_a),
    .dut_b      (dut_b),
    .dut_c      (dut_c),
    .dut_y      (dut_y),
    .err_count  (err_count),
    .fail_vec   (fail_vec),
    .fail_valid (fail_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Leaves the bench 1 time unit after the accepting edge, i.e. inside cycle 1 of the run.
  task automatic launch(input bit hold);
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Samples each cycle of a run; returns in the DONE cycle (done_cyc counts from cycle 1).
  task automatic watch_run(input bit chk_pins, output int done_cyc, output int busy_cyc);
    done_cyc = 0;
    busy_cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      if (busy) begin
        busy_cyc++;
        if (chk_pins) check_eq("pin_walk", {29'd0, dut_a, dut_b, dut_c}, (c - 1) / (Settle + 1));
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  int done_cyc;
  int busy_cyc;
  int done_seen;

  initial begin
    RST        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    model_mode = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_outputs", {busy, done, pass, dut_a, dut_b, dut_c, err_count, fail_vec, fail_valid},
             32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // Good cell
    launch(1'b0);
    check_eq("good_busy_c1", {31'd0, busy}, 32'd1);
    watch_run(1'b1, done_cyc, busy_cyc);
    check_eq("good_latency", done_cyc, Latency);
    check_eq("good_busy_cycles", busy_cyc, 8 * (Settle + 1));
    check_eq("good_pass", {31'd0, pass}, 32'd1);
    check_eq("good_err", {28'd0, err_count}, 32'd0);
    check_eq("good_fail_valid", {31'd0, fail_valid}, 32'd0);
    check_eq("good_done_pins", {29'd0, dut_a, dut_b, dut_c}, 32'd0);
    @(posedge CLK);
    #1;
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("pass_held", {31'd0, pass}, 32'd1);

    // Stuck-at-0 Y: 000, 010, 100 mismatch
    model_mode = 1;
    launch(1'b0);
    watch_run(1'b0, done_cyc, busy_cyc);
    check_eq("sa0_latency", done_cyc, Latency);
    check_eq("sa0_err", {28'd0, err_count}, 32'd3);
    check_eq("sa0_fail_vec", {29'd0, fail_vec}, 32'd0);
    check_eq("sa0_fail_valid", {31'd0, fail_valid}, 32'd1);
    check_eq("sa0_pass", {31'd0, pass}, 32'd0);

    // C open, Y = ~(A&B): 001, 011, 101 mismatch
    model_mode = 2;
    launch(1'b0);
    check_eq("copen_cleared_valid", {31'd0, fail_valid}, 32'd0);
    watch_run(1'b0, done_cyc, busy_cyc);
    check_eq("copen_latency", done_cyc, Latency);
    check_eq("copen_err", {28'd0, err_count}, 32'd3);
    check_eq("copen_fail_vec", {29'd0, fail_vec}, 32'd1);
    check_eq("copen_pass", {31'd0, pass}, 32'd0);

    // Abort while vector 5 is settling
    model_mode = 0;
    launch(1'b0);
    done_seen = 0;
    for (int c = 0; c < 100; c++) begin
      if ({dut_a, dut_b, dut_c} == 3'b101) break;
      @(posedge CLK);
      #1;
    end
    check_eq("abort_reached_v5", {29'd0, dut_a, dut_b, dut_c}, 32'd5);
    abort = 1'b1;
    @(posedge CLK);
    #1;
    abort = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_pins", {29'd0, dut_a, dut_b, dut_c}, 32'd0);
    check_eq("abort_pass", {31'd0, pass}, 32'd0);
    for (int c = 0; c < 60; c++) begin
      if (done || busy) done_seen++;
      @(posedge CLK);
      #1;
    end
    check_eq("abort_quiet", done_seen, 32'd0);

    // Asynchronous reset mid-run, with mismatches already recorded
    model_mode = 1;
    launch(1'b0);
    repeat (19) begin
      @(posedge CLK);
      #1;
    end
    check_eq("pre_rst_err", {28'd0, err_count}, 32'd2);
    #2;
    RST = 1'b1;
    #1;
    check_eq("async_rst_outputs",
             {busy, done, pass, dut_a, dut_b, dut_c, err_count, fail_vec, fail_valid}, 32'd0);
    @(negedge CLK);
    RST        = 1'b0;
    model_mode = 0;
    launch(1'b0);
    watch_run(1'b0, done_cyc, busy_cyc);
    check_eq("post_rst_latency", done_cyc, Latency);
    check_eq("post_rst_pass", {31'd0, pass}, 32'd1);

    // start and abort together in IDLE: start wins
    @(negedge CLK);
    start = 1'b1;
    abort = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_beats_abort", {31'd0, busy}, 32'd1);
    watch_run(1'b0, done_cyc, busy_cyc);
    check_eq("sba_latency", done_cyc, Latency);

    // Back-to-back: start held through DONE
    @(posedge CLK);
    #1;
    model_mode = 1;
    launch(1'b1);
    watch_run(1'b0, done_cyc, busy_cyc);
    check_eq("b2b_first_latency", done_cyc, Latency);
    check_eq("b2b_first_err", {28'd0, err_count}, 32'd3);
    model_mode = 0;
    @(posedge CLK);
    #1;
    start = 1'b0;
    check_eq("b2b_busy", {31'd0, busy}, 32'd1);
    check_eq("b2b_err_cleared", {28'd0, err_count}, 32'd0);
    check_eq("b2b_valid_cleared", {31'd0, fail_valid}, 32'd0);
    watch_run(1'b0, done_cyc, busy_cyc);
    check_eq("b2b_second_latency", done_cyc, Latency);
    check_eq("b2b_second_pass", {31'd0, pass}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
